// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: MDUOp encoding,
// default latencies and small decode helpers reused by the controller.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_result_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Ops that occupy the unit for several cycles and must be stalled on.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || is_div_op(op);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational arithmetic for the MDU: 64-bit products and quotient/remainder
// pairs, plus a divide-by-zero flag so the caller can suppress the commit.
module mdu_core
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output mdu_result_t result,
    output logic        div_zero
);

    logic        is_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        is_signed = (op == MDU_MULT) || (op == MDU_DIV);
        a_ext     = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext     = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        prod      = a_ext * b_ext;

        // Signed division on magnitudes: quotient truncates toward zero and the
        // remainder takes the dividend's sign. |0x80000000| / 1 stays 0x80000000.
        a_neg   = is_signed & a[31];
        b_neg   = is_signed & b[31];
        a_mag   = a_neg ? (~a + 32'd1) : a;
        b_mag   = b_neg ? (~b + 32'd1) : b;
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;

        div_zero = is_div_op(op) && (b == 32'd0);

        result = '0;
        if ((op == MDU_MULT) || (op == MDU_MULTU)) begin
            result = prod;
        end else if (is_div_op(op)) begin
            result.lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
            result.hi = a_neg ? (~r_mag + 32'd1) : r_mag;
        end
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div into private HI/LO,
// with mfhi/mflo/mthi/mtlo and start/busy exported to the hazard unit.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_Req,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_MDUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      p_hi;
    logic [31:0]      p_lo;
    logic             p_div_zero;
    mdu_result_t      core_result;
    logic             core_div_zero;
    logic             commit;

    mdu_core u_core (
        .op       (E_MDUOp),
        .a        (E_A),
        .b        (E_B),
        .result   (core_result),
        .div_zero (core_div_zero)
    );

    // Start/busy handshake: an op is accepted on a rising edge where E_Start=1;
    // E_Busy is then high for exactly N cycles and HI/LO update on the edge it
    // drops. Requests while busy are dropped, the hazard unit stalls them.
    assign E_Start = is_md_op(E_MDUOp) && !E_Req && !busy_q;
    assign E_Busy  = busy_q;
    assign commit  = busy_q && (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            busy_q     <= 1'b0;
            p_hi       <= '0;
            p_lo       <= '0;
            p_div_zero <= 1'b0;
        end else if (E_Start) begin
            cnt        <= is_div_op(E_MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy_q     <= 1'b1;
            p_hi       <= core_result.hi;
            p_lo       <= core_result.lo;
            p_div_zero <= core_div_zero;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (commit) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Commit wins over MT* even though the two cannot coincide in normal flow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (!p_div_zero) begin
                hi <= p_hi;
                lo <= p_lo;
            end
        end else if (!busy_q && !E_Req) begin
            if (E_MDUOp == MDU_MTHI) begin
                hi <= E_A;
            end
            if (E_MDUOp == MDU_MTLO) begin
                lo <= E_A;
            end
        end
    end

    always_comb begin
        E_MDUOut = 32'd0;
        if (E_MDUOp == MDU_MFHI) begin
            E_MDUOut = hi;
        end else if (E_MDUOp == MDU_MFLO) begin
            E_MDUOut = lo;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: fixed vector table, hand-built multi-cycle
// sequences (flush, div-by-zero, reset mid-op) and random ops against a model.
module tb_e_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic        req;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic [31:0] mdu_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    e_mdu dut (
        .clk      (clk),
        .reset    (reset),
        .E_MDUOp  (op),
        .E_Req    (req),
        .E_A      (a),
        .E_B      (b),
        .E_Start  (start),
        .E_Busy   (busy),
        .E_MDUOut (mdu_out)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %08h required %08h", tag, got, expv);
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the instruction semantics.
    function automatic void model_md(input logic [3:0] o, input logic [31:0] x,
                                     input logic [31:0] y, output logic [31:0] h,
                                     output logic [31:0] l, output logic dz);
        longint          sx;
        longint          sy;
        longint          p;
        longint unsigned ux;
        longint unsigned uy;
        longint unsigned up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        dz = 1'b0;
        h  = 32'd0;
        l  = 32'd0;
        if (o == MDU_MULT) begin
            p = sx * sy;
            {h, l} = p;
        end else if (o == MDU_MULTU) begin
            up = ux * uy;
            {h, l} = up;
        end else if (o == MDU_DIV) begin
            if (y == 32'd0) dz = 1'b1;
            else begin
                p = sx / sy;
                l = p[31:0];
                p = sx % sy;
                h = p[31:0];
            end
        end else begin
            if (y == 32'd0) dz = 1'b1;
            else begin
                up = ux / uy;
                l  = up[31:0];
                up = ux % uy;
                h  = up[31:0];
            end
        end
    endfunction

    task automatic mf_check(input string tag, input logic [31:0] eh, input logic [31:0] el);
        op = MDU_MFHI;
        #1 check({tag, " mfhi"}, mdu_out, eh);
        op = MDU_MFLO;
        #1 check({tag, " mflo"}, mdu_out, el);
        op = MDU_NONE;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic mt(input logic [3:0] o, input logic [31:0] x, input logic rq, input string tag);
        op  = o;
        a   = x;
        req = rq;
        @(negedge clk);
        check({tag, " start"}, 32'(start), 32'd0);
        @(posedge clk);
        #1;
        op  = MDU_NONE;
        req = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd0);
        if (!rq) begin
            if (o == MDU_MTHI) hi_m = x;
            else lo_m = x;
        end
        mf_check(tag, hi_m, lo_m);
    endtask

    task automatic run_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int ncyc, input logic [31:0] eh, input logic [31:0] el,
                          input string tag);
        int n;
        op  = o;
        a   = x;
        b   = y;
        req = 1'b0;
        @(negedge clk);
        check({tag, " start"}, 32'(start), 32'd1);
        @(posedge clk);
        #1;
        op = MDU_NONE;
        a  = $urandom;
        b  = $urandom;
        n  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check({tag, " busy cycles"}, 32'(n), 32'(ncyc));
        mf_check(tag, eh, el);
        hi_m = eh;
        lo_m = el;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  ops[6];
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] eh;
        logic [31:0] el;
        logic        dz;
        int          n;

        tbl[0] = '{MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5,  "mult -1x2"};
        tbl[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5,  "multu"};
        tbl[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div -7/2"};
        tbl[3] = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10, "divu 7/2"};
        tbl[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, "div ovf"};
        tbl[5] = '{MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5,  "mult max"};
        tbl[6] = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, "div 7/-2"};

        ops[0] = MDU_MULT;
        ops[1] = MDU_MULTU;
        ops[2] = MDU_DIV;
        ops[3] = MDU_DIVU;
        ops[4] = MDU_MTHI;
        ops[5] = MDU_MTLO;

        reset = 1'b1;
        op    = MDU_NONE;
        req   = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        mf_check("reset", 32'd0, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        mt(MDU_MTLO, 32'h12345678, 1'b0, "mtlo");

        for (int i = 0; i < 7; i++) begin
            run_md(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cyc, tbl[i].hi, tbl[i].lo, tbl[i].name);
        end

        mt(MDU_MTHI, 32'h0000AAAA, 1'b0, "mthi pre");
        mt(MDU_MTLO, 32'h00005555, 1'b0, "mtlo pre");
        run_md(MDU_DIVU, 32'd7, 32'd0, 10, 32'h0000AAAA, 32'h00005555, "divu by zero");

        op  = MDU_MULT;
        a   = 32'd3;
        b   = 32'd5;
        req = 1'b1;
        @(negedge clk);
        check("flushed mult start", 32'(start), 32'd0);
        @(posedge clk);
        #1;
        op  = MDU_NONE;
        req = 1'b0;
        check("flushed mult busy", 32'(busy), 32'd0);
        mf_check("flushed mult", hi_m, lo_m);
        mt(MDU_MTHI, 32'hDEADBEEF, 1'b1, "flushed mthi");

        // Flush raised two cycles into a mult must not cancel it.
        op = MDU_MULT;
        a  = 32'd6;
        b  = 32'd7;
        @(negedge clk);
        check("inflight start", 32'(start), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            op = MDU_NONE;
        end
        req = 1'b1;
        op  = MDU_MULT;
        n   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("inflight remaining busy", 32'(n), 32'd3);
        op  = MDU_NONE;
        req = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd42;
        mf_check("inflight", hi_m, lo_m);
        @(posedge clk);
        #1;

        for (int c = 9; c < 16; c++) begin
            op = 4'(c);
            a  = $urandom;
            #1;
            check("undef op start", 32'(start), 32'd0);
            check("undef op out", mdu_out, 32'd0);
        end
        op = MDU_NONE;
        @(posedge clk);
        #1;
        mf_check("after undef ops", hi_m, lo_m);

        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 5)];
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ((o == MDU_MTHI) || (o == MDU_MTLO)) begin
                mt(o, x, 1'b0, "rand mt");
            end else begin
                model_md(o, x, y, eh, el, dz);
                if (dz) begin
                    eh = hi_m;
                    el = lo_m;
                end
                exp_q.push_back(eh);
                exp_q.push_back(el);
                eh = exp_q.pop_front();
                el = exp_q.pop_front();
                run_md(o, x, y, ((o == MDU_DIV) || (o == MDU_DIVU)) ? DIV_CYCLES_DEF : MULT_CYCLES_DEF,
                       eh, el, "rand md");
            end
        end

        mt(MDU_MTHI, 32'h0BADF00D, 1'b0, "pre reset mthi");
        op = MDU_DIV;
        a  = 32'd100;
        b  = 32'd7;
        @(negedge clk);
        check("reset div start", 32'(start), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            op = MDU_NONE;
        end
        reset = 1'b1;
        #1;
        check("reset mid-op busy", 32'(busy), 32'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        mf_check("reset mid-op", hi_m, lo_m);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("post reset busy", 32'(busy), 32'd0);
        mf_check("post reset no commit", hi_m, lo_m);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
